// File: rtl/munoc_resp_return_router_pkg.sv
// Shared munoc definitions: node-ID limits, the return-router FSM encoding and
// the node-to-port decode used by the response return path.
package munoc_resp_return_router_pkg;

    localparam int unsigned MUNOC_MAX_INITIATOR     = 16;
    localparam int unsigned MUNOC_MAX_NODE_ID_WIDTH = 8;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRoute = 2'd1;
    localparam logic [1:0] StDrop  = 2'd2;

    // One-hot port select for a node ID; all-zero means the node has no return port.
    function automatic logic [MUNOC_MAX_INITIATOR-1:0] munoc_node_to_port(
        input logic [31:0] node,
        input int unsigned num_initiator
    );
        logic [MUNOC_MAX_INITIATOR-1:0] port;
        port = '0;
        for (int unsigned i = 0; i < MUNOC_MAX_INITIATOR; i++) begin
            if ((i < num_initiator) && (node == i)) begin
                port[i] = 1'b1;
            end
        end
        return port;
    endfunction

endpackage

// File: rtl/munoc_resp_fifo.sv
// Small synchronous FIFO for response beats; DEPTH must be a power of two >= 2.
module munoc_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // A push is still taken while full if the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/munoc_resp_return_router.sv
// Routes buffered response bursts to the initiator port named by the first beat's
// source node. Define MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN to add err_flag/err_node.
module munoc_resp_return_router
    import munoc_resp_return_router_pkg::*;
#(
    parameter int unsigned NUM_INITIATOR = 4,
    parameter int unsigned NODE_ID_WIDTH = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic [NODE_ID_WIDTH-1:0] rx_src_node,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_last,
    output logic [NUM_INITIATOR-1:0] tx_valid,
    input  logic [NUM_INITIATOR-1:0] tx_ready,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_last
`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
    ,
    output logic                     err_flag,
    output logic [NODE_ID_WIDTH-1:0] err_node
`endif
);

    localparam int unsigned BEAT_W = NODE_ID_WIDTH + DATA_WIDTH + 1;

    logic [BEAT_W-1:0]              wdata, rdata;
    logic                           push, pop, full, empty;
    logic [NODE_ID_WIDTH-1:0]       head_node;
    logic [DATA_WIDTH-1:0]          head_data;
    logic                           head_last;
    logic [MUNOC_MAX_INITIATOR-1:0] head_mask;
    logic [NUM_INITIATOR-1:0]       dec_port;
    logic                           dec_legal;
    logic [1:0]                     state_q, state_d;
    logic [NUM_INITIATOR-1:0]       port_q, port_d;

    assign wdata    = {rx_src_node, rx_data, rx_last};
    assign push     = rx_valid && !full;
    assign rx_ready = !full;

    munoc_resp_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstnn (rstnn),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign head_node = rdata[BEAT_W-1 -: NODE_ID_WIDTH];
    assign head_data = rdata[DATA_WIDTH:1];
    assign head_last = rdata[0];

    // Bits above NUM_INITIATOR are always zero, so OR-ing the full mask is the legality test.
    assign head_mask = munoc_node_to_port(32'(head_node), NUM_INITIATOR);
    assign dec_port  = head_mask[NUM_INITIATOR-1:0];
    assign dec_legal = |head_mask;

    assign tx_data = head_data;
    assign tx_last = head_last;

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        pop      = 1'b0;
        tx_valid = '0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    port_d  = dec_port;
                    state_d = dec_legal ? StRoute : StDrop;
                end
            end
            StRoute: begin
                // port_q is locked for the whole burst; later src_node values are ignored.
                tx_valid = port_q & {NUM_INITIATOR{!empty}};
                pop      = |(tx_valid & tx_ready);
                if (pop && head_last) state_d = StIdle;
            end
            StDrop: begin
                pop = !empty;
                if (pop && head_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q <= StIdle;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
        end
    end

`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
    logic                     err_flag_q;
    logic [NODE_ID_WIDTH-1:0] err_node_q;

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            err_flag_q <= 1'b0;
            err_node_q <= '0;
        end else if ((state_q == StIdle) && !empty && !dec_legal) begin
            err_flag_q <= 1'b1;
            if (!err_flag_q) err_node_q <= head_node;
        end
    end

    assign err_flag = err_flag_q;
    assign err_node = err_node_q;
`endif

endmodule

// File: tb/tb_munoc_resp_return_router.sv
// Directed bench for munoc_resp_return_router with default parameters.
module tb_munoc_resp_return_router;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [3:0]  rx_src_node = '0;
    logic [31:0] rx_data = '0;
    logic        rx_last = 1'b0;
    logic [3:0]  tx_valid;
    logic [3:0]  tx_ready = '0;
    logic [31:0] tx_data;
    logic        tx_last;
`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
    logic        err_flag;
    logic [3:0]  err_node;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [3:0]  bn [16];
    logic [31:0] bd [16];
    logic        bl [16];
    int          nb;
    int          acc_count;
    int          first_acc_cyc;

    logic [3:0]  obs_port [16];
    logic [31:0] obs_data [16];
    logic        obs_last [16];
    int          obs_cyc  [16];
    int          obs_n;
    int          valid_cycles;
    int          first_valid_cyc;

    munoc_resp_return_router dut (
        .clk         (clk),
        .rstnn       (rstnn),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_src_node (rx_src_node),
        .rx_data     (rx_data),
        .rx_last     (rx_last),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_last     (tx_last)
`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
        ,
        .err_flag    (err_flag),
        .err_node    (err_node)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers bn/bd/bl[0..nb-1] on rx with a bounded wait for rx_ready per beat.
    task automatic drive_burst();
        acc_count = 0;
        first_acc_cyc = -1;
        for (int i = 0; i < nb; i++) begin
            rx_valid = 1'b1;
            rx_src_node = bn[i];
            rx_data = bd[i];
            rx_last = bl[i];
            for (int w = 0; w < 50 && !rx_ready; w++) step();
            if (!rx_ready) begin
                tests++;
                fails++;
                $display("FAIL drive_timeout: beat %0d got rx_ready=0, required 1", i);
                break;
            end
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            step();
            acc_count++;
        end
        rx_valid = 1'b0;
        rx_last = 1'b0;
    endtask

    // Samples one point per cycle; records handshaken beats until 'want' are seen.
    task automatic collect(input int max_cycles, input int want);
        int c;
        obs_n = 0;
        valid_cycles = 0;
        first_valid_cyc = -1;
        c = 0;
        while (c < max_cycles && !(want > 0 && obs_n >= want)) begin
            if (tx_valid != '0) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if ((tx_valid & tx_ready) != '0 && obs_n < 16) begin
                obs_port[obs_n] = tx_valid;
                obs_data[obs_n] = tx_data;
                obs_last[obs_n] = tx_last;
                obs_cyc[obs_n] = cyc;
                obs_n++;
            end
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (tx_valid !== 4'b0000) begin
            fails++;
            $display("FAIL reset_tx_valid: got %b, required 0000", tx_valid);
        end
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_rx_ready: got %b, required 1", rx_ready);
        end
`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
        tests++;
        if (err_flag !== 1'b0 || err_node !== 4'd0) begin
            fails++;
            $display("FAIL reset_err: got flag=%b node=%0d, required 0/0", err_flag, err_node);
        end
`endif
        rstnn = 1'b1;
        step();
        tests++;
        if (rx_ready !== 1'b1 || tx_valid !== 4'b0000) begin
            fails++;
            $display("FAIL release_state: got rx_ready=%b tx_valid=%b, required 1/0000",
                     rx_ready, tx_valid);
        end
    endtask

    task automatic test_route_burst();
        logic [31:0] exp_d;
        tx_ready = 4'hF;
        nb = 4;
        for (int i = 0; i < 4; i++) begin
            bn[i] = 4'd2;
            bd[i] = 32'hA000_0000 + 32'(i);
            bl[i] = (i == 3);
        end
        step();
        fork
            drive_burst();
            collect(20, 4);
        join
        tests++;
        if (obs_n !== 4) begin
            fails++;
            $display("FAIL route_count: got %0d beats, required 4", obs_n);
        end
        for (int i = 0; i < obs_n; i++) begin
            exp_d = 32'hA000_0000 + 32'(i);
            tests++;
            if (obs_port[i] !== 4'b0100 || obs_data[i] !== exp_d || obs_last[i] !== (i == 3)) begin
                fails++;
                $display("FAIL route_beat%0d: got port=%b data=%h last=%b, required 0100/%h/%b",
                         i, obs_port[i], obs_data[i], obs_last[i], exp_d, (i == 3));
            end
            if (i > 0) begin
                tests++;
                if (obs_cyc[i] !== obs_cyc[0] + i) begin
                    fails++;
                    $display("FAIL route_rate%0d: got cycle %0d, required %0d",
                             i, obs_cyc[i], obs_cyc[0] + i);
                end
            end
        end
        tests++;
        if (first_valid_cyc - first_acc_cyc !== 2) begin
            fails++;
            $display("FAIL route_latency: got %0d cycles, required 2",
                     first_valid_cyc - first_acc_cyc);
        end
        tests++;
        if (valid_cycles !== 4) begin
            fails++;
            $display("FAIL route_valid_cycles: got %0d, required 4", valid_cycles);
        end
    endtask

    task automatic test_drop_illegal();
        tx_ready = 4'hF;
        nb = 1;
        bn[0] = 4'd7;
        bd[0] = 32'hDEAD_0007;
        bl[0] = 1'b1;
        step();
        fork
            drive_burst();
            collect(8, 0);
        join
        tests++;
        if (valid_cycles !== 0) begin
            fails++;
            $display("FAIL drop7_valid: got %0d valid cycles, required 0", valid_cycles);
        end
        tests++;
        if (rx_ready !== 1'b1 || acc_count !== 1) begin
            fails++;
            $display("FAIL drop7_consumed: got rx_ready=%b accepted=%0d, required 1/1",
                     rx_ready, acc_count);
        end
`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
        tests++;
        if (err_flag !== 1'b1 || err_node !== 4'd7) begin
            fails++;
            $display("FAIL drop7_err: got flag=%b node=%0d, required 1/7", err_flag, err_node);
        end
`endif
        nb = 2;
        bn[0] = 4'd1;
        bd[0] = 32'h1111_0000;
        bl[0] = 1'b0;
        bn[1] = 4'd1;
        bd[1] = 32'h1111_0001;
        bl[1] = 1'b1;
        fork
            drive_burst();
            collect(20, 2);
        join
        tests++;
        if (obs_n !== 2) begin
            fails++;
            $display("FAIL after_drop_count: got %0d beats, required 2", obs_n);
        end
        for (int i = 0; i < obs_n; i++) begin
            tests++;
            if (obs_port[i] !== 4'b0010 || obs_data[i] !== bd[i] || obs_last[i] !== bl[i]) begin
                fails++;
                $display("FAIL after_drop_beat%0d: got port=%b data=%h last=%b, required 0010/%h/%b",
                         i, obs_port[i], obs_data[i], obs_last[i], bd[i], bl[i]);
            end
        end
    endtask

    task automatic test_drop_node9();
        tx_ready = 4'hF;
        nb = 2;
        bn[0] = 4'd9;
        bd[0] = 32'h9999_0000;
        bl[0] = 1'b0;
        bn[1] = 4'd1;
        bd[1] = 32'h9999_0001;
        bl[1] = 1'b1;
        step();
        fork
            drive_burst();
            collect(10, 0);
        join
        tests++;
        if (valid_cycles !== 0 || acc_count !== 2) begin
            fails++;
            $display("FAIL drop9: got valid_cycles=%0d accepted=%0d, required 0/2",
                     valid_cycles, acc_count);
        end
`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
        tests++;
        if (err_flag !== 1'b1 || err_node !== 4'd7) begin
            fails++;
            $display("FAIL drop9_err_first: got flag=%b node=%0d, required 1/7", err_flag, err_node);
        end
`endif
    endtask

    task automatic test_node_lock();
        tx_ready = 4'hF;
        nb = 3;
        bn[0] = 4'd3;
        bd[0] = 32'h3333_0000;
        bl[0] = 1'b0;
        bn[1] = 4'd0;
        bd[1] = 32'h3333_0001;
        bl[1] = 1'b0;
        bn[2] = 4'd3;
        bd[2] = 32'h3333_0002;
        bl[2] = 1'b1;
        step();
        fork
            drive_burst();
            collect(20, 3);
        join
        tests++;
        if (obs_n !== 3) begin
            fails++;
            $display("FAIL lock_count: got %0d beats, required 3", obs_n);
        end
        for (int i = 0; i < obs_n; i++) begin
            tests++;
            if (obs_port[i] !== 4'b1000 || obs_data[i] !== bd[i] || obs_last[i] !== bl[i]) begin
                fails++;
                $display("FAIL lock_beat%0d: got port=%b data=%h last=%b, required 1000/%h/%b",
                         i, obs_port[i], obs_data[i], obs_last[i], bd[i], bl[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        tx_ready = 4'b1101;
        nb = 4;
        for (int i = 0; i < 4; i++) begin
            bn[i] = 4'd1;
            bd[i] = 32'hB000_0000 + 32'(i);
            bl[i] = (i == 3);
        end
        step();
        fork
            drive_burst();
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (tx_valid == '0 && w < 10) begin
                    @(negedge clk);
                    w++;
                end
                tests++;
                if (tx_valid == '0) begin
                    fails++;
                    $display("FAIL bp_wait_valid: got tx_valid=0000 after %0d cycles, required 0010", w);
                end
                for (int s = 0; s < 5; s++) begin
                    tests++;
                    if (tx_valid !== 4'b0010 || tx_data !== 32'hB000_0000 || tx_last !== 1'b0) begin
                        fails++;
                        $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b, required 0010/b0000000/0",
                                 s, tx_valid, tx_data, tx_last);
                    end
                    tests++;
                    if (rx_ready !== 1'b0 || acc_count !== 2) begin
                        fails++;
                        $display("FAIL bp_full%0d: got rx_ready=%b accepted=%0d, required 0/2",
                                 s, rx_ready, acc_count);
                    end
                    if (s < 4) @(negedge clk);
                end
                tx_ready = 4'hF;
                collect(20, 4);
            end
        join
        tests++;
        if (obs_n !== 4) begin
            fails++;
            $display("FAIL bp_count: got %0d beats, required 4", obs_n);
        end
        for (int i = 0; i < obs_n; i++) begin
            tests++;
            if (obs_port[i] !== 4'b0010 || obs_data[i] !== bd[i] || obs_last[i] !== bl[i]) begin
                fails++;
                $display("FAIL bp_beat%0d: got port=%b data=%h last=%b, required 0010/%h/%b",
                         i, obs_port[i], obs_data[i], obs_last[i], bd[i], bl[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_p [3];
        exp_p[0] = 4'b0001;
        exp_p[1] = 4'b0001;
        exp_p[2] = 4'b1000;
        tx_ready = 4'hF;
        nb = 3;
        bn[0] = 4'd0;
        bd[0] = 32'hC0C0_0000;
        bl[0] = 1'b0;
        bn[1] = 4'd0;
        bd[1] = 32'hC0C0_0001;
        bl[1] = 1'b1;
        bn[2] = 4'd3;
        bd[2] = 32'hC3C3_0000;
        bl[2] = 1'b1;
        step();
        fork
            drive_burst();
            collect(20, 3);
        join
        tests++;
        if (obs_n !== 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d beats, required 3", obs_n);
        end
        for (int i = 0; i < obs_n && i < 3; i++) begin
            tests++;
            if (obs_port[i] !== exp_p[i] || obs_data[i] !== bd[i] || obs_last[i] !== bl[i]) begin
                fails++;
                $display("FAIL b2b_beat%0d: got port=%b data=%h last=%b, required %b/%h/%b",
                         i, obs_port[i], obs_data[i], obs_last[i], exp_p[i], bd[i], bl[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        tx_ready = 4'hF;
        step();
        rx_valid = 1'b1;
        rx_src_node = 4'd0;
        rx_data = 32'hE000_0000;
        rx_last = 1'b0;
        step();
        rx_data = 32'hE000_0001;
        step();
        rx_data = 32'hE000_0002;
        tests++;
        if (tx_valid !== 4'b0001 || tx_data !== 32'hE000_0000) begin
            fails++;
            $display("FAIL mid_pre_reset: got valid=%b data=%h, required 0001/e0000000",
                     tx_valid, tx_data);
        end
        @(negedge clk);
        rstnn = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 4'b0000 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_now: got valid=%b rx_ready=%b, required 0000/1",
                     tx_valid, rx_ready);
        end
`ifdef MUNOC_RESP_RETURN_ROUTER_ERR_STATUS_EN
        tests++;
        if (err_flag !== 1'b0 || err_node !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset_err: got flag=%b node=%0d, required 0/0", err_flag, err_node);
        end
`endif
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rstnn = 1'b1;
        step();
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_release_ready: got %b, required 1", rx_ready);
        end
        collect(8, 0);
        tests++;
        if (valid_cycles !== 0) begin
            fails++;
            $display("FAIL mid_residual: got %0d valid cycles, required 0", valid_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_route_burst();
        test_drop_illegal();
        test_drop_node9();
        test_node_lock();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
